branch_pred_queue: RTL and testbench
====================================

BRANCH_PRED_QUEUE -- requirements
Module: branch_pred_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 8, number of in-flight branch entries (power of two, 2..16).
REQ-002 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: enq  in  1  fetch pushes one predicted branch.
REQ-005 SHALL have port: enq_pc  in  16 (lc3b_word)  PC of fetched branch.
REQ-006 SHALL have port: enq_bht  in  4 (lc3b_bht_out)  history snapshot used for the prediction.
REQ-007 SHALL have port: enq_pred  in  1  predicted direction (1 = taken).
REQ-008 SHALL have port: resolve  in  1  oldest branch resolved, in program order.
REQ-009 SHALL have port: resolve_taken  in  1  actual direction of the oldest branch.
REQ-010 SHALL have port: flush  in  1  discard all entries after a redirect.
REQ-011 SHALL have port: ld_pred_unit  out  1  predictor update strobe.
REQ-012 SHALL have port: old_pc  out  16  PC of the resolved branch.
REQ-013 SHALL have port: bht_taken  out  4  history snapshot of the resolved branch.
REQ-014 SHALL have port: taken_in  out  1  actual direction of the resolved branch.
REQ-015 SHALL have port: mispredict  out  1  one-cycle pulse: stored prediction differed from actual.
REQ-016 SHALL have port: full / empty  out  1 each  occupancy flags.
REQ-017 SHALL have port: count  out  $clog2(DEPTH)+1  current occupancy.
REQ-018 SHALL have port: stat_resolved / stat_mispred  out  16 each  statistics counters.

Function
REQ-019 SHALL store {pc, bht, pred} at the tail on an accepted enq; accepted = enq & (~full | accepted resolve) & ~flush.
REQ-020 SHALL pop the head on an accepted resolve; accepted = resolve & ~empty. Resolve while empty SHALL be ignored, with no strobe.
REQ-021 SHALL, one cycle after an accepted resolve, assert ld_pred_unit=1 with old_pc, bht_taken and taken_in taken from the popped entry and resolve_taken. Outputs SHALL be registered.
REQ-022 SHALL assert mispredict in the same cycle as ld_pred_unit when popped pred != resolve_taken; otherwise 0.
REQ-023 SHALL keep ld_pred_unit and mispredict at 0 in every cycle not following an accepted resolve. old_pc, bht_taken and taken_in SHALL hold their last values.
REQ-024 SHALL, on enq while full without a resolve, drop the enq; contents and count SHALL be unchanged.
REQ-025 SHALL, on enq and resolve in the same cycle while full, accept both; count is unchanged.
REQ-026 SHALL wrap head/tail pointers modulo DEPTH. full = (count==DEPTH) and empty = (count==0), both combinational from count.
REQ-027 SHALL, on flush, process a simultaneous resolve first (strobe next cycle), then set head=tail=0 and count=0. A simultaneous enq SHALL be dropped.

Reset
REQ-028 SHALL, while rst=1, clear pointers, set count=0, empty=1, full=0, ld_pred_unit=0, mispredict=0, old_pc=0, bht_taken=0, taken_in=0, stat_resolved=0 and stat_mispred=0.
REQ-029 SHALL give rst priority over flush, enq and resolve. Reset mid-operation discards all entries, and no strobe SHALL follow.
REQ-030 SHALL NOT require the storage array to be reset.

Configuration
REQ-031 SHALL, with BPQ_STATS_EN defined, increment stat_resolved on every accepted resolve and stat_mispred on every mispredict. Both SHALL saturate at 16'hFFFF and be cleared only by rst.
REQ-032 SHALL, without BPQ_STATS_EN, tie stat_resolved and stat_mispred to 0 and infer no counter logic; ports SHALL remain present.

Structure
REQ-033 SHALL take lc3b_word and lc3b_bht_out from lc3b_types. A packed entry typedef lc3b_bpq_entry {pc, bht, pred} and a constant BPQ_DEPTH_DEFAULT=8 SHALL be added to lc3b_types.
REQ-034 SHALL place the saturating counter in sub-module bpq_stat_counter, instantiated twice under BPQ_STATS_EN.

Verification
REQ-035 SHALL cover in-order update: enq pc=16'h3006, bht=4'b1010, pred=1; resolve taken=1 -> next cycle ld_pred_unit=1, old_pc=16'h3006, bht_taken=4'b1010, taken_in=1, mispredict=0.
REQ-036 SHALL cover mispredict: enq pred=0, then resolve taken=1 -> next cycle ld_pred_unit=1, mispredict=1, stat_mispred increments by 1 (BPQ_STATS_EN).
REQ-037 SHALL cover full/wrap: 8 enqs -> full=1, count=8; 9th enq dropped; then 8 resolves return PCs in enq order; then 3 more enq/resolve pairs confirm pointer wrap.
REQ-038 SHALL cover simultaneous events: full queue with enq+resolve in the same cycle -> count stays 8 and the new entry surfaces 8th. Resolve while empty -> no strobe.
REQ-039 SHALL cover flush: 5 entries plus flush+resolve+enq in the same cycle -> one strobe for the head entry, then count=0, empty=1, enq dropped.
REQ-040 SHALL cover reset mid-operation: 3 entries, rst=1 for 1 cycle coinciding with resolve -> no ld_pred_unit, count=0, stats=0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types, plus the branch prediction queue entry layout.
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_bht_out;

    typedef struct packed {
        lc3b_word    pc;
        lc3b_bht_out bht;
        logic        pred;
    } lc3b_bpq_entry;

    localparam int BPQ_DEPTH_DEFAULT = 8;
endpackage

// File: rtl/branch_pred_queue_if.sv
// Fetch/resolve side of the branch prediction queue; slave = queue, master = driver.
interface branch_pred_queue_if
    import lc3b_types::*;
#(
    parameter int DEPTH = BPQ_DEPTH_DEFAULT
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          enq;
    lc3b_word      enq_pc;
    lc3b_bht_out   enq_bht;
    logic          enq_pred;
    logic          resolve;
    logic          resolve_taken;
    logic          flush;

    logic          ld_pred_unit;
    lc3b_word      old_pc;
    lc3b_bht_out   bht_taken;
    logic          taken_in;
    logic          mispredict;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [15:0]   stat_resolved;
    logic [15:0]   stat_mispred;

    modport master (
        output enq, enq_pc, enq_bht, enq_pred, resolve, resolve_taken, flush,
        input  ld_pred_unit, old_pc, bht_taken, taken_in, mispredict,
               full, empty, count, stat_resolved, stat_mispred
    );

    modport slave (
        input  enq, enq_pc, enq_bht, enq_pred, resolve, resolve_taken, flush,
        output ld_pred_unit, old_pc, bht_taken, taken_in, mispredict,
               full, empty, count, stat_resolved, stat_mispred
    );
endinterface

// File: rtl/branch_pred_queue_stat_counter.sv
// 16-bit saturating event counter, cleared only by reset.
module bpq_stat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] value
);
    always_ff @(posedge clk) begin
        if (rst)
            value <= 16'd0;
        else if (inc && value != 16'hFFFF)
            value <= value + 16'd1;
    end
endmodule

// File: rtl/branch_pred_queue.sv
// In-order queue of predicted branches; pops on resolve and strobes the predictor update.
// Optional statistics counters are built when BPQ_STATS_EN is defined.
module branch_pred_queue
    import lc3b_types::*;
#(
    parameter int DEPTH = BPQ_DEPTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    branch_pred_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    lc3b_bpq_entry mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          res_acc, enq_acc, mis_now;
    lc3b_bpq_entry head_e;

    logic          ld_q, mis_q, taken_q;
    lc3b_word      pc_q;
    lc3b_bht_out   bht_q;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head_e  = mem[head];
    assign res_acc = bus.resolve & ~empty;
    // A resolve in the same cycle frees a slot, so a full queue may still accept.
    assign enq_acc = bus.enq & (~full | res_acc) & ~bus.flush;
    assign mis_now = res_acc & (head_e.pred != bus.resolve_taken);

    always_ff @(posedge clk) begin
        if (enq_acc && !rst)
            mem[tail] <= '{pc: bus.enq_pc, bht: bus.enq_bht, pred: bus.enq_pred};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ld_q    <= 1'b0;
            mis_q   <= 1'b0;
            pc_q    <= '0;
            bht_q   <= '0;
            taken_q <= 1'b0;
        end else begin
            ld_q  <= res_acc;
            mis_q <= mis_now;
            if (res_acc) begin
                pc_q    <= head_e.pc;
                bht_q   <= head_e.bht;
                taken_q <= bus.resolve_taken;
            end
            if (bus.flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq_acc) tail <= tail + PW'(1);
                if (res_acc) head <= head + PW'(1);
                count <= count + CW'(enq_acc) - CW'(res_acc);
            end
        end
    end

    assign bus.ld_pred_unit = ld_q;
    assign bus.mispredict   = mis_q;
    assign bus.old_pc       = pc_q;
    assign bus.bht_taken    = bht_q;
    assign bus.taken_in     = taken_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = count;

`ifdef BPQ_STATS_EN
    bpq_stat_counter u_stat_resolved (
        .clk   (clk),
        .rst   (rst),
        .inc   (res_acc),
        .value (bus.stat_resolved)
    );
    bpq_stat_counter u_stat_mispred (
        .clk   (clk),
        .rst   (rst),
        .inc   (mis_now),
        .value (bus.stat_mispred)
    );
`else
    assign bus.stat_resolved = 16'd0;
    assign bus.stat_mispred  = 16'd0;
`endif
endmodule

// File: tb/tb_branch_pred_queue.sv
// Directed checks of branch_pred_queue: update path, mispredict, full/wrap, flush, reset.
module tb_branch_pred_queue;
    import lc3b_types::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_res = 0;
    int   exp_mis = 0;

    branch_pred_queue_if #(.DEPTH(DEPTH)) bus ();

    branch_pred_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string tag);
`ifdef BPQ_STATS_EN
        chk({tag, "_stat_res"}, 32'(bus.stat_resolved), 32'(exp_res));
        chk({tag, "_stat_mis"}, 32'(bus.stat_mispred), 32'(exp_mis));
`else
        chk({tag, "_stat_res"}, 32'(bus.stat_resolved), 32'd0);
        chk({tag, "_stat_mis"}, 32'(bus.stat_mispred), 32'd0);
`endif
    endtask

    task automatic do_enq(input logic [15:0] pc, input logic [3:0] bht, input logic pred);
        bus.enq = 1'b1; bus.enq_pc = pc; bus.enq_bht = bht; bus.enq_pred = pred;
        step();
        bus.enq = 1'b0;
    endtask

    // Resolve the head and check the strobe against the entry expected there.
    task automatic do_res(input string tag, input logic taken, input logic [15:0] pc,
                          input logic [3:0] bht, input logic pred);
        bus.resolve = 1'b1; bus.resolve_taken = taken;
        step();
        bus.resolve = 1'b0;
        exp_res++;
        if (pred != taken) exp_mis++;
        chk({tag, "_ld"},    32'(bus.ld_pred_unit), 32'd1);
        chk({tag, "_pc"},    32'(bus.old_pc), 32'(pc));
        chk({tag, "_bht"},   32'(bus.bht_taken), 32'(bht));
        chk({tag, "_taken"}, 32'(bus.taken_in), 32'(taken));
        chk({tag, "_mis"},   32'(bus.mispredict), 32'(pred != taken));
        chk_stats(tag);
    endtask

    initial begin
        bus.enq = 1'b0; bus.enq_pc = '0; bus.enq_bht = '0; bus.enq_pred = 1'b0;
        bus.resolve = 1'b0; bus.resolve_taken = 1'b0; bus.flush = 1'b0;

        // reset state
        step(); step();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full",  32'(bus.full), 32'd0);
        chk("rst_ld",    32'(bus.ld_pred_unit), 32'd0);
        chk("rst_mis",   32'(bus.mispredict), 32'd0);
        chk("rst_pc",    32'(bus.old_pc), 32'd0);
        chk("rst_bht",   32'(bus.bht_taken), 32'd0);
        chk("rst_taken", 32'(bus.taken_in), 32'd0);
        chk_stats("rst");
        rst = 1'b0;

        // in-order update
        do_enq(16'h3006, 4'b1010, 1'b1);
        chk("upd_count", 32'(bus.count), 32'd1);
        chk("upd_empty", 32'(bus.empty), 32'd0);
        do_res("upd", 1'b1, 16'h3006, 4'b1010, 1'b1);
        chk("upd_count0", 32'(bus.count), 32'd0);
        step();
        chk("upd_ld_drop", 32'(bus.ld_pred_unit), 32'd0);
        chk("upd_pc_hold", 32'(bus.old_pc), 32'h3006);

        // mispredict
        do_enq(16'h3100, 4'h5, 1'b0);
        do_res("mis", 1'b1, 16'h3100, 4'h5, 1'b0);
        step();
        chk("mis_drop", 32'(bus.mispredict), 32'd0);

        // fill, drop overflow, drain in order
        for (int i = 0; i < DEPTH; i++) do_enq(16'h4000 + 16'(i), 4'(i), i[0]);
        chk("full_flag",  32'(bus.full), 32'd1);
        chk("full_count", 32'(bus.count), 32'd8);
        do_enq(16'h4FFF, 4'hF, 1'b1);
        chk("ovf_count", 32'(bus.count), 32'd8);
        for (int i = 0; i < DEPTH; i++) do_res($sformatf("drain%0d", i), 1'b1, 16'h4000 + 16'(i), 4'(i), i[0]);
        chk("drain_empty", 32'(bus.empty), 32'd1);
        for (int k = 0; k < 3; k++) begin
            do_enq(16'h5000 + 16'(k), 4'(k + 8), 1'b1);
            do_res($sformatf("wrap%0d", k), 1'b0, 16'h5000 + 16'(k), 4'(k + 8), 1'b1);
        end

        // simultaneous enq+resolve while full
        for (int i = 0; i < DEPTH; i++) do_enq(16'h6000 + 16'(i), 4'h3, 1'b1);
        bus.enq = 1'b1; bus.enq_pc = 16'h6100; bus.enq_bht = 4'hC; bus.enq_pred = 1'b0;
        do_res("simul", 1'b1, 16'h6000, 4'h3, 1'b1);
        bus.enq = 1'b0;
        chk("simul_count", 32'(bus.count), 32'd8);
        for (int i = 1; i < DEPTH; i++) do_res($sformatf("simd%0d", i), 1'b1, 16'h6000 + 16'(i), 4'h3, 1'b1);
        do_res("simnew", 1'b0, 16'h6100, 4'hC, 1'b0);
        bus.resolve = 1'b1; bus.resolve_taken = 1'b1;
        step();
        bus.resolve = 1'b0;
        chk("empty_res_ld", 32'(bus.ld_pred_unit), 32'd0);
        chk("empty_res_pc", 32'(bus.old_pc), 32'h6100);
        chk_stats("empty_res");

        // flush with simultaneous resolve and enq
        for (int i = 0; i < 5; i++) do_enq(16'h7000 + 16'(i), 4'h6, 1'b1);
        bus.flush = 1'b1;
        bus.enq = 1'b1; bus.enq_pc = 16'h7777; bus.enq_bht = 4'h7; bus.enq_pred = 1'b1;
        do_res("flush", 1'b0, 16'h7000, 4'h6, 1'b1);
        bus.flush = 1'b0; bus.enq = 1'b0;
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_empty", 32'(bus.empty), 32'd1);
        step();
        chk("flush_ld1", 32'(bus.ld_pred_unit), 32'd0);
        do_enq(16'h7100, 4'h1, 1'b0);
        do_res("postflush", 1'b0, 16'h7100, 4'h1, 1'b0);

        // reset mid-operation coinciding with resolve
        for (int i = 0; i < 3; i++) do_enq(16'h8000 + 16'(i), 4'h2, 1'b0);
        rst = 1'b1; bus.resolve = 1'b1; bus.resolve_taken = 1'b1;
        step();
        rst = 1'b0; bus.resolve = 1'b0;
        exp_res = 0; exp_mis = 0;
        chk("mrst_ld",    32'(bus.ld_pred_unit), 32'd0);
        chk("mrst_count", 32'(bus.count), 32'd0);
        chk("mrst_empty", 32'(bus.empty), 32'd1);
        chk_stats("mrst");
        step();
        chk("mrst_ld2", 32'(bus.ld_pred_unit), 32'd0);
        chk("mrst_mis2", 32'(bus.mispredict), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
